// File: rtl/spi_pixel_loader.sv
// spi_pixel_loader: oversampling SPI slave that turns host pixel-write frames into single pixel writes for sram_wrapper
module spi_pixel_loader #(
   parameter int PRECISION    = 11,
   parameter int PIXEL_SIZE   = 16,
   parameter int LINE_WIDTH   = 800,
   parameter int FRAME_HEIGHT = 600
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  spi_sclk,
   input  logic                  spi_cs_n,
   input  logic                  spi_mosi,
   output logic                  spi_active,
   output logic [PIXEL_SIZE-1:0] spi_pixel_data,
   output logic [PRECISION-1:0]  spi_pixel_x,
   output logic [PRECISION-1:0]  spi_pixel_y,
   input  logic                  spi_pixel_ack,
   output logic                  overflow,
   output logic                  frame_error
);
   localparam logic [PRECISION-1:0] LW_MAX = PRECISION'(LINE_WIDTH - 1);
   localparam logic [PRECISION-1:0] FH_MAX = PRECISION'(FRAME_HEIGHT - 1);
   localparam logic [PRECISION-1:0] LW     = PRECISION'(LINE_WIDTH);
   localparam logic [PRECISION-1:0] FH     = PRECISION'(FRAME_HEIGHT);
   typedef enum logic [2:0] {IDLE, CMD, XCOORD, YCOORD, PIXEL, DISCARD} state_t;
   state_t               state;
   logic [2:0]           sclk_q, cs_q, mosi_q;
   logic [15:0]          shreg;
   logic [3:0]           bit_cnt;
   logic                 word_rdy, reject;
   logic [PRECISION-1:0] x_cur, y_cur;
   logic                 sample, cs_fall, cs_rise, last_bit, hi_bits;
   assign sample   = sclk_q[1] & ~sclk_q[2] & ~cs_q[1];
   assign cs_fall  = ~cs_q[1] & cs_q[2];
   assign cs_rise  = cs_q[1] & ~cs_q[2];
   assign last_bit = (state == CMD) ? bit_cnt == 4'd7 : bit_cnt == 4'd15;
   assign hi_bits  = |shreg[15:PRECISION];
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_q         <= 3'b000;
         cs_q           <= 3'b111;
         mosi_q         <= 3'b000;
         state          <= IDLE;
         shreg          <= '0;
         bit_cnt        <= '0;
         word_rdy       <= 1'b0;
         reject         <= 1'b0;
         x_cur          <= '0;
         y_cur          <= '0;
         spi_active     <= 1'b0;
         spi_pixel_data <= '0;
         spi_pixel_x    <= '0;
         spi_pixel_y    <= '0;
         overflow       <= 1'b0;
         frame_error    <= 1'b0;
      end else begin
         sclk_q   <= {sclk_q[1:0], spi_sclk};
         cs_q     <= {cs_q[1:0], spi_cs_n};
         mosi_q   <= {mosi_q[1:0], spi_mosi};
         word_rdy <= 1'b0;
         if (spi_active && spi_pixel_ack)
            spi_active <= 1'b0;
         if (cs_fall) begin
            state       <= CMD;
            bit_cnt     <= '0;
            reject      <= 1'b0;
            overflow    <= 1'b0;
            frame_error <= 1'b0;
         end else if (cs_rise) begin
            state   <= IDLE;
            bit_cnt <= '0;
         end else begin
            if (sample && state != IDLE && state != DISCARD) begin
               shreg    <= {shreg[14:0], mosi_q[2]};
               bit_cnt  <= last_bit ? 4'd0 : bit_cnt + 4'd1;
               word_rdy <= last_bit;
            end
            if (word_rdy) begin
               case (state)
                  CMD: state <= (shreg[7:0] == 8'h01) ? XCOORD : DISCARD;
                  XCOORD: begin
                     x_cur  <= shreg[PRECISION-1:0];
                     reject <= hi_bits;
                     state  <= YCOORD;
                  end
                  YCOORD: begin
                     y_cur <= shreg[PRECISION-1:0];
                     if (reject || hi_bits || x_cur >= LW || shreg[PRECISION-1:0] >= FH) begin
                        frame_error <= 1'b1;
                        state       <= DISCARD;
                     end else
                        state <= PIXEL;
                  end
                  PIXEL: begin
                     if (!spi_active || spi_pixel_ack) begin
                        spi_active     <= 1'b1;
                        spi_pixel_data <= shreg[PIXEL_SIZE-1:0];
                        spi_pixel_x    <= x_cur;
                        spi_pixel_y    <= y_cur;
                     end else
                        overflow <= 1'b1;
                     x_cur <= (x_cur == LW_MAX) ? '0 : x_cur + PRECISION'(1);
                     if (x_cur == LW_MAX)
                        y_cur <= (y_cur == FH_MAX) ? '0 : y_cur + PRECISION'(1);
                  end
                  default: ;
               endcase
            end
         end
      end
   end
endmodule
